// File: rtl/vadd_pkg.sv
// Shared definitions for the pipelined SIMD add/sub unit: SEW codes,
// opSel bit positions and saturation constants.
package vadd_pkg;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_e;

    localparam int unsigned OP_REV = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_SGN = 2;
    localparam int unsigned OP_SAT = 3;
    localparam int unsigned OP_CIN = 4;

    function automatic int unsigned elem_count(input logic [1:0] sew, input int unsigned width);
        return width / (32'd8 << sew);
    endfunction

    // Values are element-sized, held in the low bytes of a 64-bit word.
    function automatic logic [63:0] sat_max(input logic [1:0] sew);
        case (sew)
            SEW_8:   return 64'h0000_0000_0000_007F;
            SEW_16:  return 64'h0000_0000_0000_7FFF;
            SEW_32:  return 64'h0000_0000_7FFF_FFFF;
            default: return 64'h7FFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] sat_min(input logic [1:0] sew);
        case (sew)
            SEW_8:   return 64'h0000_0000_0000_0080;
            SEW_16:  return 64'h0000_0000_0000_8000;
            SEW_32:  return 64'h0000_0000_8000_0000;
            default: return 64'h8000_0000_0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/vadd_seg_adder.sv
// 64-bit segmented adder slice: a set break bit starts a new element at that
// byte, taking its carry from inject instead of the byte below.
module vadd_seg_adder (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [7:0]  brk,
    input  logic [7:0]  inject,
    output logic [63:0] sum,
    output logic [7:0]  cout
);

    always_comb begin
        logic       c;
        logic [8:0] t;
        c    = 1'b0;
        t    = '0;
        sum  = '0;
        cout = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            if (brk[j]) c = inject[j];
            t = {1'b0, a[8*j +: 8]} + {1'b0, b[8*j +: 8]} + {8'b0, c};
            sum[8*j +: 8] = t[7:0];
            cout[j]       = t[8];
            c             = t[8];
        end
    end

endmodule

// File: rtl/vadd_sat_pipe.sv
// Two-stage pipelined packed add/sub with carry in/out and optional
// saturation (enabled by defining VADD_SAT_EN).
module vadd_sat_pipe
    import vadd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned SEW_WIDTH   = 2,
    parameter int unsigned OPSEL_WIDTH = 6,
    parameter int unsigned TAG_WIDTH   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   vec0,
    input  logic [DATA_WIDTH-1:0]   vec1,
    input  logic [DATA_WIDTH/8-1:0] carry_in,
    input  logic [SEW_WIDTH-1:0]    sew,
    input  logic [OPSEL_WIDTH-1:0]  opSel,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   result,
    output logic [DATA_WIDTH/8-1:0] carry_out,
    output logic                    sat_flag,
    output logic [TAG_WIDTH-1:0]    out_tag
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned NS = DATA_WIDTH / 64;

    logic                  s1_adv, s2_adv;
    logic                  sub_c, rev_c;
    logic [DATA_WIDTH-1:0] x_c, y_c, b_c, sum_c;
    logic [NB-1:0]         brk_c, inj_c, cout_c;

    logic                  s1_valid, s1_sub;
    logic [DATA_WIDTH-1:0] s1_sum;
    logic [NB-1:0]         s1_cout;
    logic [1:0]            s1_sew;
    logic [TAG_WIDTH-1:0]  s1_tag;

    logic [DATA_WIDTH-1:0] res_c;
    logic [NB-1:0]         co_c;
    logic                  sat_c;

    logic unused_inputs;
    assign unused_inputs = ^{opSel, sew};

    assign s2_adv    = ~out_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv & rst;

    // Subtraction is X + ~Y + 1; a borrow-in simply clears that +1.
    always_comb begin
        int unsigned nbe;
        sub_c = opSel[OP_SUB];
        rev_c = sub_c & opSel[OP_REV];
        x_c   = rev_c ? vec1 : vec0;
        y_c   = rev_c ? vec0 : vec1;
        b_c   = sub_c ? ~y_c : y_c;
        nbe   = 32'd1 << sew[1:0];
        for (int unsigned j = 0; j < NB; j++) begin
            brk_c[j] = (j & (nbe - 1)) == 0;
            inj_c[j] = opSel[OP_CIN] ? (carry_in[j >> sew[1:0]] ^ sub_c) : sub_c;
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_slice
        vadd_seg_adder u_seg (
            .a      (x_c[64*s +: 64]),
            .b      (b_c[64*s +: 64]),
            .brk    (brk_c[8*s +: 8]),
            .inject (inj_c[8*s +: 8]),
            .sum    (sum_c[64*s +: 64]),
            .cout   (cout_c[8*s +: 8])
        );
    end

`ifdef VADD_SAT_EN
    logic [NB-1:0] xmsb_c, bmsb_c;
    logic [NB-1:0] s1_xmsb, s1_bmsb;
    logic          s1_sgn, s1_sat;

    always_comb begin
        for (int unsigned j = 0; j < NB; j++) begin
            xmsb_c[j] = x_c[8*j + 7];
            bmsb_c[j] = b_c[8*j + 7];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_xmsb <= '0;
            s1_bmsb <= '0;
            s1_sgn  <= 1'b0;
            s1_sat  <= 1'b0;
        end else if (s1_adv && in_valid) begin
            s1_xmsb <= xmsb_c;
            s1_bmsb <= bmsb_c;
            s1_sgn  <= opSel[OP_SGN];
            s1_sat  <= opSel[OP_SAT];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_cout  <= '0;
            s1_sew   <= '0;
            s1_sub   <= 1'b0;
            s1_tag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum  <= sum_c;
                s1_cout <= cout_c;
                s1_sew  <= sew[1:0];
                s1_sub  <= sub_c;
                s1_tag  <= in_tag;
            end
        end
    end

    // Every byte decides its clamp from the top byte of its own element.
    always_comb begin
        int unsigned nb, cnt;
        nb    = 32'd1 << s1_sew;
        cnt   = elem_count(s1_sew, DATA_WIDTH);
        res_c = s1_sum;
        co_c  = '0;
        sat_c = 1'b0;
        for (int unsigned k = 0; k < NB; k++) begin
            if (k < cnt) co_c[k] = s1_cout[k*nb + nb - 1] ^ s1_sub;
        end
`ifdef VADD_SAT_EN
        begin
            logic [63:0] smax, smin;
            logic [7:0]  fill;
            logic        ovf;
            int unsigned lb, off;
            smax = sat_max(s1_sew);
            smin = sat_min(s1_sew);
            for (int unsigned j = 0; j < NB; j++) begin
                lb  = j | (nb - 1);
                off = j & (nb - 1);
                if (s1_sgn) begin
                    ovf  = (s1_xmsb[lb] == s1_bmsb[lb]) && (s1_sum[8*lb + 7] != s1_xmsb[lb]);
                    fill = s1_xmsb[lb] ? smin[8*off +: 8] : smax[8*off +: 8];
                end else begin
                    ovf  = s1_cout[lb] ^ s1_sub;
                    fill = s1_sub ? 8'h00 : 8'hFF;
                end
                if (s1_sat && ovf) begin
                    res_c[8*j +: 8] = fill;
                    sat_c           = 1'b1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= '0;
            sat_flag  <= 1'b0;
            out_tag   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result    <= res_c;
                carry_out <= co_c;
                sat_flag  <= sat_c;
                out_tag   <= s1_tag;
            end
        end
    end

endmodule
